// File: rtl/sdram_arb_pkg.sv
// Shared definitions for the SDRAM port arbiter: ownership states,
// read-tag owner encoding and a constant-width helper.
package sdram_arb_pkg;

   typedef enum logic [1:0] {
      ST_USER    = 2'd0,
      ST_SPI     = 2'd1,
      ST_RELEASE = 2'd2
   } arb_state_t;

   localparam logic TAG_USER = 1'b0;
   localparam logic TAG_SPI  = 1'b1;

   // Ceiling log2, never less than 1 so it can size a counter directly.
   function automatic int clog2(input int value);
      int result;
      result = 0;
      while ((1 << result) < value) begin
         result = result + 1;
      end
      return (result < 1) ? 1 : result;
   endfunction

endpackage

// File: rtl/rd_tag_fifo.sv
// Small FIFO remembering which requester issued each outstanding read.
// The head entry is visible combinationally so a returning rd_ready can be
// routed in the same cycle it arrives.
module rd_tag_fifo
   import sdram_arb_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic push,
   input  logic pop,
   input  logic din,
   output logic dout,
   output logic full,
   output logic empty
);

   localparam int PW = clog2(DEPTH);

   logic [DEPTH-1:0] mem;
   logic [PW:0]      wr_ptr;
   logic [PW:0]      rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign dout    = mem[rd_ptr[PW-1:0]];

   // Pointer and storage update; push and pop may happen together.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         mem    <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr[PW-1:0]] <= din;
            wr_ptr              <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
      end
   end

endmodule

// File: rtl/sdram_arbiter.sv
// Shares the single SDRAM controller port between the latency-critical SPI
// read path and the best-effort user command path. SPI takes the port
// combinationally on spi_lock; user requests that cannot go out are parked
// in a one-entry slot and replayed after a holdoff window.
module sdram_arbiter
   import sdram_arb_pkg::*;
#(
   parameter int ADDR_BITS   = 25,
   parameter int TAG_DEPTH   = 4,
   parameter int HOLDOFF     = 4,
   parameter int MAX_INHIBIT = 4096
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 spi_lock,
   input  logic                 spi_enable,
   input  logic [ADDR_BITS-1:0] spi_addr,
   input  logic                 spi_pause_cas,
   output logic                 spi_busy,
   output logic                 spi_rd_ready,
   input  logic                 user_enable,
   input  logic                 user_we,
   input  logic [ADDR_BITS-1:0] user_addr,
   input  logic [7:0]           user_wr_data,
   input  logic                 user_refresh_inhibit,
   output logic                 user_busy,
   output logic                 user_rd_ready,
   output logic                 sd_enable,
   output logic                 sd_we,
   output logic [ADDR_BITS-1:0] sd_addr,
   output logic [7:0]           sd_wr_data,
   output logic                 sd_refresh_inhibit,
   output logic                 sd_pause_cas,
   input  logic                 sd_busy,
   input  logic                 sd_rd_ready,
   output logic                 inhibit_overrun
);

   localparam int                HOLD_W    = clog2(HOLDOFF + 1);
   localparam int                WD_W      = clog2(MAX_INHIBIT + 1);
   localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLDOFF - 1);
   localparam logic [WD_W-1:0]   WD_MAX    = WD_W'(MAX_INHIBIT);

   arb_state_t           state;
   arb_state_t           state_next;
   logic [HOLD_W-1:0]    hold_cnt;
   logic [HOLD_W-1:0]    hold_next;

   logic                 pend_valid;
   logic                 pend_we;
   logic [ADDR_BITS-1:0] pend_addr;
   logic [7:0]           pend_data;

   logic [WD_W-1:0]      wd_cnt;
   logic [WD_W-1:0]      wd_next;
   logic                 wd_block;
   logic                 overrun;

   logic                 owner_spi;
   logic                 user_slot_open;
   logic                 pend_issue;
   logic                 user_accept;
   logic                 pend_capture;

   logic                 mux_enable;
   logic                 mux_we;
   logic [ADDR_BITS-1:0] mux_addr;
   logic [7:0]           mux_data;
   logic                 mux_pause;
   logic                 src_inhibit;

   logic                 tag_push;
   logic                 tag_pop;
   logic                 tag_din;
   logic                 tag_dout;
   logic                 tag_full;
   logic                 tag_empty;

   assign owner_spi      = spi_lock || (state == ST_SPI);
   assign user_slot_open = !owner_spi && (state == ST_USER) && !sd_busy && !tag_full;
   assign pend_issue     = user_slot_open && pend_valid;
   assign user_accept    = user_slot_open && !pend_valid && user_enable;
   assign pend_capture   = user_enable && !pend_valid && !user_slot_open;

   // Ownership state register with the holdoff countdown.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= ST_USER;
         hold_cnt <= '0;
      end else begin
         state    <= state_next;
         hold_cnt <= hold_next;
      end
   end

   // Next ownership state: SPI lock always wins, release drains the holdoff.
   always_comb begin
      state_next = state;
      hold_next  = hold_cnt;
      case (state)
         ST_USER: begin
            if (spi_lock) begin
               state_next = ST_SPI;
            end
         end
         ST_SPI: begin
            if (!spi_lock) begin
               state_next = ST_RELEASE;
               hold_next  = HOLD_LOAD;
            end
         end
         ST_RELEASE: begin
            if (spi_lock) begin
               state_next = ST_SPI;
            end else if (hold_cnt == '0) begin
               state_next = ST_USER;
            end else begin
               hold_next = hold_cnt - 1'b1;
            end
         end
         default: begin
            state_next = ST_USER;
         end
      endcase
   end

   // One-entry parking slot for user requests that arrive while blocked.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pend_valid <= 1'b0;
         pend_we    <= 1'b0;
         pend_addr  <= '0;
         pend_data  <= '0;
      end else if (pend_capture) begin
         pend_valid <= 1'b1;
         pend_we    <= user_we;
         pend_addr  <= user_addr;
         pend_data  <= user_wr_data;
      end else if (pend_issue) begin
         pend_valid <= 1'b0;
      end
   end

   // Controller port mux: SPI fields when it owns the port, else user or slot.
   always_comb begin
      mux_enable  = 1'b0;
      mux_we      = 1'b0;
      mux_addr    = user_addr;
      mux_data    = 8'h00;
      mux_pause   = 1'b0;
      src_inhibit = 1'b0;
      if (owner_spi) begin
         mux_enable  = spi_enable && !sd_busy && !tag_full;
         mux_addr    = spi_addr;
         mux_pause   = spi_pause_cas;
         src_inhibit = 1'b1;
      end else begin
         if (pend_valid) begin
            mux_we   = pend_we;
            mux_addr = pend_addr;
            mux_data = pend_data;
         end else begin
            mux_we   = user_we;
            mux_data = user_wr_data;
         end
         mux_enable  = pend_issue || user_accept;
         src_inhibit = (state == ST_RELEASE) ? 1'b0 : user_refresh_inhibit;
      end
   end

   assign wd_next = (wd_cnt == WD_MAX) ? wd_cnt : wd_cnt + 1'b1;

   // Refresh-inhibit watchdog: saturating run length, sticky overrun flag.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wd_cnt   <= '0;
         wd_block <= 1'b0;
         overrun  <= 1'b0;
      end else if (src_inhibit) begin
         wd_cnt <= wd_next;
         if (wd_next == WD_MAX) begin
            wd_block <= 1'b1;
            overrun  <= 1'b1;
         end
      end else begin
         wd_cnt   <= '0;
         wd_block <= 1'b0;
      end
   end

   assign tag_push = mux_enable && !mux_we;
   assign tag_din  = owner_spi ? TAG_SPI : TAG_USER;
   assign tag_pop  = sd_rd_ready && !tag_empty;

   rd_tag_fifo #(
      .DEPTH (TAG_DEPTH)
   ) u_tag_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (tag_push),
      .pop   (tag_pop),
      .din   (tag_din),
      .dout  (tag_dout),
      .full  (tag_full),
      .empty (tag_empty)
   );

   assign sd_enable          = rst_n && mux_enable;
   assign sd_we              = rst_n && mux_we;
   assign sd_addr            = rst_n ? mux_addr : '0;
   assign sd_wr_data         = rst_n ? mux_data : 8'h00;
   assign sd_pause_cas       = rst_n && mux_pause;
   assign sd_refresh_inhibit = rst_n && src_inhibit && !wd_block;
   assign spi_busy           = rst_n && (sd_busy || tag_full);
   assign user_busy          = !rst_n || owner_spi || (state != ST_USER) || sd_busy
                               || pend_valid || tag_full;
   assign spi_rd_ready       = rst_n && tag_pop && (tag_dout == TAG_SPI);
   assign user_rd_ready      = rst_n && tag_pop && (tag_dout == TAG_USER);
   assign inhibit_overrun    = rst_n && overrun;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Randomized and directed bench for sdram_arbiter against a cycle-level
// reference model built from ownership history, a tag queue and a run length.
module tb_sdram_arbiter;
   import sdram_arb_pkg::*;

   localparam int ADDR_BITS   = 25;
   localparam int TAG_DEPTH   = 4;
   localparam int HOLDOFF     = 4;
   localparam int MAX_INHIBIT = 4096;

   typedef struct packed {
      logic                 rst_n;
      logic                 spi_lock;
      logic                 spi_enable;
      logic [ADDR_BITS-1:0] spi_addr;
      logic                 spi_pause_cas;
      logic                 user_enable;
      logic                 user_we;
      logic [ADDR_BITS-1:0] user_addr;
      logic [7:0]           user_wr_data;
      logic                 user_refresh_inhibit;
      logic                 sd_busy;
      logic                 sd_rd_ready;
   } stim_t;

   logic                 clk = 1'b0;
   logic                 rst_n = 1'b0;
   logic                 spi_lock = 1'b0;
   logic                 spi_enable = 1'b0;
   logic [ADDR_BITS-1:0] spi_addr = '0;
   logic                 spi_pause_cas = 1'b0;
   logic                 spi_busy;
   logic                 spi_rd_ready;
   logic                 user_enable = 1'b0;
   logic                 user_we = 1'b0;
   logic [ADDR_BITS-1:0] user_addr = '0;
   logic [7:0]           user_wr_data = 8'h00;
   logic                 user_refresh_inhibit = 1'b0;
   logic                 user_busy;
   logic                 user_rd_ready;
   logic                 sd_enable;
   logic                 sd_we;
   logic [ADDR_BITS-1:0] sd_addr;
   logic [7:0]           sd_wr_data;
   logic                 sd_refresh_inhibit;
   logic                 sd_pause_cas;
   logic                 sd_busy = 1'b0;
   logic                 sd_rd_ready = 1'b0;
   logic                 inhibit_overrun;

   stim_t                stim;
   int                   compared = 0;
   int                   mismatched = 0;
   int                   cycle = 0;

   int                   k_since_lock;
   logic                 tagq[$];
   logic                 m_pend_valid;
   logic                 m_pend_we;
   logic [ADDR_BITS-1:0] m_pend_addr;
   logic [7:0]           m_pend_data;
   int                   wd_run;
   logic                 wd_blocked;
   logic                 m_overrun;

   sdram_arbiter #(
      .ADDR_BITS   (ADDR_BITS),
      .TAG_DEPTH   (TAG_DEPTH),
      .HOLDOFF     (HOLDOFF),
      .MAX_INHIBIT (MAX_INHIBIT)
   ) dut (
      .clk                  (clk),
      .rst_n                (rst_n),
      .spi_lock             (spi_lock),
      .spi_enable           (spi_enable),
      .spi_addr             (spi_addr),
      .spi_pause_cas        (spi_pause_cas),
      .spi_busy             (spi_busy),
      .spi_rd_ready         (spi_rd_ready),
      .user_enable          (user_enable),
      .user_we              (user_we),
      .user_addr            (user_addr),
      .user_wr_data         (user_wr_data),
      .user_refresh_inhibit (user_refresh_inhibit),
      .user_busy            (user_busy),
      .user_rd_ready        (user_rd_ready),
      .sd_enable            (sd_enable),
      .sd_we                (sd_we),
      .sd_addr              (sd_addr),
      .sd_wr_data           (sd_wr_data),
      .sd_refresh_inhibit   (sd_refresh_inhibit),
      .sd_pause_cas         (sd_pause_cas),
      .sd_busy              (sd_busy),
      .sd_rd_ready          (sd_rd_ready),
      .inhibit_overrun      (inhibit_overrun)
   );

   // 10 ns clock.
   initial begin
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      compared = compared + 1;
      if (observed !== expected) begin
         mismatched = mismatched + 1;
         $display("[TB] FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h",
                  tag, cycle, observed, expected);
      end
   endtask

   task automatic resetModel();
      k_since_lock = HOLDOFF + 1;
      tagq.delete();
      m_pend_valid = 1'b0;
      m_pend_we    = 1'b0;
      m_pend_addr  = '0;
      m_pend_data  = 8'h00;
      wd_run       = 0;
      wd_blocked   = 1'b0;
      m_overrun    = 1'b0;
   endtask

   task automatic idle();
      stim       = '0;
      stim.rst_n = 1'b1;
   endtask

   // Drive one cycle of stimulus, compare every output against the model,
   // then advance the model across the clock edge.
   task automatic applyStimulus();
      logic                 owner, user_st, full, slot_open, pend_issue, do_pop;
      logic                 e_en, e_we, e_pause, e_src, e_ref;
      logic                 e_spi_rd, e_user_rd, e_spi_busy, e_user_busy;
      logic [ADDR_BITS-1:0] e_addr;
      logic [7:0]           e_data;
      @(negedge clk);
      rst_n                = stim.rst_n;
      spi_lock             = stim.spi_lock;
      spi_enable           = stim.spi_enable;
      spi_addr             = stim.spi_addr;
      spi_pause_cas        = stim.spi_pause_cas;
      user_enable          = stim.user_enable;
      user_we              = stim.user_we;
      user_addr            = stim.user_addr;
      user_wr_data         = stim.user_wr_data;
      user_refresh_inhibit = stim.user_refresh_inhibit;
      sd_busy              = stim.sd_busy;
      sd_rd_ready          = stim.sd_rd_ready;
      #1;
      owner      = stim.spi_lock || (k_since_lock == 0);
      user_st    = (k_since_lock > HOLDOFF);
      full       = (tagq.size() == TAG_DEPTH);
      slot_open  = !owner && user_st && !stim.sd_busy && !full;
      pend_issue = slot_open && m_pend_valid;
      do_pop     = stim.sd_rd_ready && (tagq.size() > 0);
      e_we       = 1'b0;
      e_pause    = 1'b0;
      e_addr     = '0;
      e_data     = 8'h00;
      if (owner) begin
         e_en    = stim.spi_enable && !stim.sd_busy && !full;
         e_addr  = stim.spi_addr;
         e_pause = stim.spi_pause_cas;
         e_src   = 1'b1;
      end else if (m_pend_valid) begin
         e_en   = slot_open;
         e_we   = m_pend_we;
         e_addr = m_pend_addr;
         e_data = m_pend_data;
         e_src  = user_st && stim.user_refresh_inhibit;
      end else begin
         e_en   = slot_open && stim.user_enable;
         e_we   = stim.user_we;
         e_addr = stim.user_addr;
         e_data = stim.user_wr_data;
         e_src  = user_st && stim.user_refresh_inhibit;
      end
      e_ref       = e_src && !wd_blocked;
      e_spi_rd    = do_pop && (tagq[0] == TAG_SPI);
      e_user_rd   = do_pop && (tagq[0] == TAG_USER);
      e_spi_busy  = stim.sd_busy || full;
      e_user_busy = owner || !user_st || stim.sd_busy || m_pend_valid || full;

      if (!stim.rst_n) begin
         checkOutput("rst_sd_enable", 32'(sd_enable), 32'd0);
         checkOutput("rst_sd_we", 32'(sd_we), 32'd0);
         checkOutput("rst_sd_addr", 32'(sd_addr), 32'd0);
         checkOutput("rst_sd_wr_data", 32'(sd_wr_data), 32'd0);
         checkOutput("rst_sd_pause_cas", 32'(sd_pause_cas), 32'd0);
         checkOutput("rst_sd_refresh_inhibit", 32'(sd_refresh_inhibit), 32'd0);
         checkOutput("rst_spi_busy", 32'(spi_busy), 32'd0);
         checkOutput("rst_user_busy", 32'(user_busy), 32'd1);
         checkOutput("rst_spi_rd_ready", 32'(spi_rd_ready), 32'd0);
         checkOutput("rst_user_rd_ready", 32'(user_rd_ready), 32'd0);
         checkOutput("rst_inhibit_overrun", 32'(inhibit_overrun), 32'd0);
      end else begin
         checkOutput("sd_enable", 32'(sd_enable), 32'(e_en));
         if (e_en) begin
            checkOutput("sd_we", 32'(sd_we), 32'(e_we));
            checkOutput("sd_addr", 32'(sd_addr), 32'(e_addr));
            if (e_we) begin
               checkOutput("sd_wr_data", 32'(sd_wr_data), 32'(e_data));
            end
         end
         checkOutput("sd_pause_cas", 32'(sd_pause_cas), 32'(e_pause));
         checkOutput("sd_refresh_inhibit", 32'(sd_refresh_inhibit), 32'(e_ref));
         checkOutput("spi_busy", 32'(spi_busy), 32'(e_spi_busy));
         checkOutput("user_busy", 32'(user_busy), 32'(e_user_busy));
         checkOutput("spi_rd_ready", 32'(spi_rd_ready), 32'(e_spi_rd));
         checkOutput("user_rd_ready", 32'(user_rd_ready), 32'(e_user_rd));
         checkOutput("inhibit_overrun", 32'(inhibit_overrun), 32'(m_overrun));
      end

      @(posedge clk);
      cycle = cycle + 1;
      if (!stim.rst_n) begin
         resetModel();
      end else begin
         if (do_pop) begin
            void'(tagq.pop_front());
         end
         if (e_en && !e_we) begin
            tagq.push_back(owner ? TAG_SPI : TAG_USER);
         end
         if (pend_issue) begin
            m_pend_valid = 1'b0;
         end else if (stim.user_enable && !m_pend_valid && !slot_open) begin
            m_pend_valid = 1'b1;
            m_pend_we    = stim.user_we;
            m_pend_addr  = stim.user_addr;
            m_pend_data  = stim.user_wr_data;
         end
         if (e_src) begin
            if (wd_run < MAX_INHIBIT) begin
               wd_run = wd_run + 1;
            end
            if (wd_run == MAX_INHIBIT) begin
               wd_blocked = 1'b1;
               m_overrun  = 1'b1;
            end
         end else begin
            wd_run     = 0;
            wd_blocked = 1'b0;
         end
         if (stim.spi_lock) begin
            k_since_lock = 0;
         end else if (k_since_lock <= HOLDOFF) begin
            k_since_lock = k_since_lock + 1;
         end
      end
   endtask

   initial begin
      logic lock_r;
      resetModel();

      // Reset with noisy inputs.
      stim = '0;
      stim.sd_busy     = 1'b1;
      stim.sd_rd_ready = 1'b1;
      stim.user_addr   = 25'h1ABCDEF;
      repeat (2) applyStimulus();

      // User read of 0x100, data returns six cycles later.
      idle();
      applyStimulus();
      stim.user_enable = 1'b1;
      stim.user_addr   = 25'h0000100;
      applyStimulus();
      idle();
      repeat (5) applyStimulus();
      stim.sd_rd_ready = 1'b1;
      applyStimulus();

      // User read in flight, SPI grabs the port with a same-cycle read.
      idle();
      stim.user_enable = 1'b1;
      stim.user_addr   = 25'h0000200;
      applyStimulus();
      idle();
      stim.spi_lock   = 1'b1;
      stim.spi_enable = 1'b1;
      stim.spi_addr   = 25'h0000010;
      applyStimulus();
      idle();
      stim.spi_lock = 1'b1;
      repeat (3) applyStimulus();
      stim.sd_rd_ready = 1'b1;
      repeat (2) applyStimulus();

      // User write parked during the lock, replayed after the holdoff.
      idle();
      stim.spi_lock     = 1'b1;
      stim.user_enable  = 1'b1;
      stim.user_we      = 1'b1;
      stim.user_addr    = 25'h0001234;
      stim.user_wr_data = 8'h55;
      applyStimulus();
      idle();
      stim.spi_lock = 1'b1;
      applyStimulus();
      idle();
      repeat (8) applyStimulus();

      // Lock re-asserts during release while a user read is parked.
      idle();
      stim.spi_lock    = 1'b1;
      stim.user_enable = 1'b1;
      stim.user_addr   = 25'h0000300;
      applyStimulus();
      idle();
      repeat (2) applyStimulus();
      stim.spi_lock = 1'b1;
      repeat (2) applyStimulus();
      idle();
      repeat (8) applyStimulus();
      stim.sd_rd_ready = 1'b1;
      repeat (3) applyStimulus();

      // Four outstanding reads fill the tag FIFO; a fifth is held back.
      idle();
      for (int i = 0; i < 5; i++) begin
         stim.user_enable = 1'b1;
         stim.user_addr   = ADDR_BITS'(32'h400 + i);
         applyStimulus();
      end
      idle();
      stim.spi_lock   = 1'b1;
      stim.spi_enable = 1'b1;
      applyStimulus();
      idle();
      repeat (6) applyStimulus();
      stim.sd_rd_ready = 1'b1;
      applyStimulus();
      idle();
      repeat (2) applyStimulus();
      stim.sd_rd_ready = 1'b1;
      repeat (6) applyStimulus();

      // Randomized traffic with lock bursts and occasional resets.
      lock_r = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 19) == 0) begin
            lock_r = !lock_r;
         end
         stim.rst_n                = ($urandom_range(0, 599) != 0);
         stim.spi_lock             = lock_r;
         stim.spi_enable           = 1'($urandom_range(0, 1));
         stim.spi_addr             = ADDR_BITS'($urandom);
         stim.spi_pause_cas        = 1'($urandom_range(0, 1));
         stim.user_enable          = ($urandom_range(0, 2) == 0);
         stim.user_we              = 1'($urandom_range(0, 1));
         stim.user_addr            = ADDR_BITS'($urandom);
         stim.user_wr_data         = 8'($urandom);
         stim.user_refresh_inhibit = ($urandom_range(0, 3) != 0);
         stim.sd_busy              = ($urandom_range(0, 3) == 0);
         stim.sd_rd_ready          = ($urandom_range(0, 2) == 0);
         applyStimulus();
      end

      // Watchdog: a lock held past the inhibit limit trips the sticky flag.
      idle();
      repeat (8) applyStimulus();
      stim.spi_lock    = 1'b1;
      stim.sd_rd_ready = 1'b1;
      repeat (MAX_INHIBIT - 1) applyStimulus();
      #1;
      checkOutput("wd_flag_before_limit", 32'(inhibit_overrun), 32'd0);
      checkOutput("wd_inhibit_before_limit", 32'(sd_refresh_inhibit), 32'd1);
      applyStimulus();
      #1;
      checkOutput("wd_flag_at_limit", 32'(inhibit_overrun), 32'd1);
      checkOutput("wd_inhibit_forced_low", 32'(sd_refresh_inhibit), 32'd0);
      repeat (4) applyStimulus();
      idle();
      repeat (10) applyStimulus();
      #1;
      checkOutput("wd_flag_sticky", 32'(inhibit_overrun), 32'd1);
      stim.rst_n = 1'b0;
      applyStimulus();
      idle();
      applyStimulus();
      #1;
      checkOutput("wd_flag_cleared_by_reset", 32'(inhibit_overrun), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
